// File: rtl/controller_arbiter_pkg.sv
// Shared definitions for the round-robin bus arbiter.
//   N_CONTROLLERS           number of requesting controllers
//   CTRL_IDX_W              width of a controller index
//   DEFAULT_TIMEOUT_CYCLES  ack-less granted cycles before forced release
//   DEFAULT_COUNTER_WIDTH   default timeout counter width
//   arb_state_e             arbiter FSM state encoding
//   idx_onehot()            controller index to one-hot vector
package controller_arbiter_pkg;

   localparam int N_CONTROLLERS          = 4;
   localparam int CTRL_IDX_W             = 2;
   localparam int DEFAULT_TIMEOUT_CYCLES = 1024;
   localparam int DEFAULT_COUNTER_WIDTH  = 16;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_GRANT   = 2'd1,
      ST_RELEASE = 2'd2
   } arb_state_e;

   function automatic logic [N_CONTROLLERS-1:0] idx_onehot(input logic [CTRL_IDX_W-1:0] idx);
      return N_CONTROLLERS'(1) << idx;
   endfunction

endpackage

// File: rtl/rr_priority_select.sv
// Rotating first-one picker.
//   eligible  in   per-controller candidate vector
//   last      in   index of the previous owner; search starts at last+1
//   winner    out  first set bit of eligible found from last+1 upward (wraps)
//   any       out  eligible has at least one bit set
module rr_priority_select
   import controller_arbiter_pkg::*;
(
   input  logic [N_CONTROLLERS-1:0] eligible,
   input  logic [CTRL_IDX_W-1:0]    last,
   output logic [CTRL_IDX_W-1:0]    winner,
   output logic                     any
);

   logic [CTRL_IDX_W-1:0] idx;

   always_comb begin
      winner = last;
      any    = 1'b0;
      idx    = '0;
      for (int i = 0; i < N_CONTROLLERS; i++) begin
         // index arithmetic wraps naturally in CTRL_IDX_W bits
         idx = last + CTRL_IDX_W'(i) + CTRL_IDX_W'(1);
         if (!any && eligible[idx]) begin
            winner = idx;
            any    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/controller_round_robin_arbiter.sv
// Round-robin arbiter granting one of four bus controllers access to a
// shared device, with an ack-less timeout that forcibly releases and masks
// a stuck owner until it drops its request.
//
//   state      | meaning
//   -----------+-----------------------------------------------------
//   ST_IDLE    | no owner, waiting for an eligible request
//   ST_GRANT   | controllerSelected owns the bus, timeout counter runs
//   ST_RELEASE | one-cycle bus gap before the next owner
//
// Ports
//   wb_clk_i            in   clock
//   wb_rst_i            in   asynchronous reset, active-low
//   request[3:0]        in   cyc of controllers 3..0
//   device_ack_o        in   device ack
//   device_error_o      in   device error
//   controllerSelected  out  registered index driving the device mux
//   grantValid          out  registered; controllerSelected owns the bus
//   timeoutError[3:0]   out  one-cycle pulse to the timed-out controller
//   probe_state[1:0]    out  current FSM state
module controller_round_robin_arbiter
   import controller_arbiter_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
   parameter int COUNTER_WIDTH  = DEFAULT_COUNTER_WIDTH
) (
   input  logic                     wb_clk_i,
   input  logic                     wb_rst_i,
   input  logic [N_CONTROLLERS-1:0] request,
   input  logic                     device_ack_o,
   input  logic                     device_error_o,
   output logic [CTRL_IDX_W-1:0]    controllerSelected,
   output logic                     grantValid,
   output logic [N_CONTROLLERS-1:0] timeoutError,
   output logic [1:0]               probe_state
);

   localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
   localparam logic [COUNTER_WIDTH-1:0] CNT_LAST =
      COUNTER_WIDTH'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

   arb_state_e                 state_q, state_d;
   logic [CTRL_IDX_W-1:0]      sel_q, sel_d;
   logic [CTRL_IDX_W-1:0]      last_q, last_d;
   logic                       gv_q, gv_d;
   logic [N_CONTROLLERS-1:0]   mask_q, mask_d;
   logic [COUNTER_WIDTH-1:0]   cnt_q, cnt_d;

   logic [N_CONTROLLERS-1:0]   eligible;
   logic [CTRL_IDX_W-1:0]      winner;
   logic                       any_elig;
   logic                       owner_req;
   logic                       ack_any;
   logic                       timeout_hit;

   assign eligible  = request & ~mask_q;
   assign owner_req = request[sel_q];
   assign ack_any   = device_ack_o | device_error_o;

   // owner_req in the term makes a same-cycle request drop win over timeout,
   // and ack_any makes an ack win over timeout
   assign timeout_hit = TIMEOUT_EN && (state_q == ST_GRANT) && owner_req &&
                        !ack_any && (cnt_q == CNT_LAST);

   rr_priority_select u_pick (
      .eligible (eligible),
      .last     (last_q),
      .winner   (winner),
      .any      (any_elig)
   );

   always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
      if (!wb_rst_i) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:    if (any_elig) state_d = ST_GRANT;
         ST_GRANT:   if (!owner_req || timeout_hit) state_d = ST_RELEASE;
         ST_RELEASE: state_d = any_elig ? ST_GRANT : ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      sel_d        = sel_q;
      last_d       = last_q;
      cnt_d        = cnt_q;
      mask_d       = mask_q & request;
      gv_d         = (state_d == ST_GRANT);
      timeoutError = '0;

      if ((state_q != ST_GRANT) && (state_d == ST_GRANT)) begin
         sel_d = winner;
         cnt_d = '0;
      end

      if (state_q == ST_GRANT) begin
         cnt_d = ack_any ? '0 : cnt_q + COUNTER_WIDTH'(1);
         if (state_d == ST_RELEASE) last_d = sel_q;
         if (timeout_hit) begin
            timeoutError = idx_onehot(sel_q);
            mask_d       = (mask_q & request) | idx_onehot(sel_q);
         end
      end
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
      if (!wb_rst_i) begin
         sel_q  <= '0;
         last_q <= CTRL_IDX_W'(N_CONTROLLERS - 1);
         gv_q   <= 1'b0;
         mask_q <= '0;
         cnt_q  <= '0;
      end else begin
         sel_q  <= sel_d;
         last_q <= last_d;
         gv_q   <= gv_d;
         mask_q <= mask_d;
         cnt_q  <= cnt_d;
      end
   end

   assign controllerSelected = sel_q;
   assign grantValid         = gv_q;
   assign probe_state        = state_q;

endmodule
